// File: rtl/fb_scanout_reader_pkg.sv
// Shared graphics definitions: video timing widths, memory latency, swap FSM states.
package fb_scanout_reader_pkg;

  localparam int unsigned HCOUNT_W    = 11;
  localparam int unsigned VCOUNT_W    = 10;
  localparam int unsigned RD_LATENCY  = 2;
  localparam int unsigned DEPTH_PIX_W = 8;
  // Address register + memory read + pixel register.
  localparam int unsigned PIPE_DEPTH  = RD_LATENCY + 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } swap_state_t;

endpackage

// File: rtl/fb_scanout_reader_pipe_delay.sv
// Fixed-depth shift register used to align flags and syncs with read data.
module pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per clock; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fb_scanout_reader.sv
// Double-buffered framebuffer scanout: address generation, read pipeline,
// pixel select and vsync-aligned buffer swap.
module fb_scanout_reader
  import fb_scanout_reader_pkg::*;
#(
  parameter int unsigned FB_ADDR_WIDTH   = 17,
  parameter int unsigned FB_BIT_WIDTH    = 8,
  parameter int unsigned DEPTH_BIT_WIDTH = 16,
  parameter int unsigned FB_W            = 320,
  parameter int unsigned FB_H            = 180,
  parameter int unsigned SCALE_SHIFT     = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [HCOUNT_W-1:0]        hcount_in,
  input  logic [VCOUNT_W-1:0]        vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       active_in,
  input  logic                       swap_req_in,
  input  logic                       depth_view_in,
  input  logic [FB_BIT_WIDTH-1:0]    fb0_data_in,
  input  logic [FB_BIT_WIDTH-1:0]    fb1_data_in,
  input  logic [DEPTH_BIT_WIDTH-1:0] dp_data_in,
  output logic [FB_ADDR_WIDTH-1:0]   rd_addr_out,
  output logic                       rd_en_out,
  output logic                       front_out,
  output logic                       swap_ack_out,
  output logic [FB_BIT_WIDTH-1:0]    pixel_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       active_out
);

  localparam logic [HCOUNT_W-1:0] FB_W_X = HCOUNT_W'(FB_W);
  localparam logic [VCOUNT_W-1:0] FB_H_Y = VCOUNT_W'(FB_H);

  logic [HCOUNT_W-1:0]      buf_x;
  logic [VCOUNT_W-1:0]      buf_y;
  logic                     in_range;
  logic [FB_ADDR_WIDTH-1:0] addr_next;

  // Downscale screen coordinates and form the linear buffer address.
  always_comb begin
    buf_x     = hcount_in >> SCALE_SHIFT;
    buf_y     = vcount_in >> SCALE_SHIFT;
    in_range  = (buf_x < FB_W_X) && (buf_y < FB_H_Y);
    addr_next = '0;
    if (in_range) begin
      addr_next = FB_ADDR_WIDTH'(buf_y) * FB_ADDR_WIDTH'(FB_W) + FB_ADDR_WIDTH'(buf_x);
    end
  end

  // Issue the shared read to both colour buffers and the depth buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_addr_out <= '0;
      rd_en_out   <= 1'b0;
    end else begin
      rd_addr_out <= addr_next;
      rd_en_out   <= active_in && in_range;
    end
  end

  // Selection flags travel with the address so each pixel uses the buffer it was read from.
  logic px_active, px_in_range, px_depth, px_front;

  pipe_delay #(.WIDTH(4), .DEPTH(RD_LATENCY + 1)) u_flag_pipe (
    .clk (clk_in),
    .rst (rst_in),
    .d   ({active_in, in_range, depth_view_in, front_out}),
    .q   ({px_active, px_in_range, px_depth, px_front})
  );

  pipe_delay #(.WIDTH(3), .DEPTH(PIPE_DEPTH)) u_sync_pipe (
    .clk (clk_in),
    .rst (rst_in),
    .d   ({hsync_in, vsync_in, active_in}),
    .q   ({hsync_out, vsync_out, active_out})
  );

  logic [DEPTH_PIX_W-1:0]  depth_pix;
  logic [FB_BIT_WIDTH-1:0] pixel_next;

  // Near depth shows bright: invert the depth MSBs.
  always_comb begin
    depth_pix  = ~dp_data_in[DEPTH_BIT_WIDTH-1 -: DEPTH_PIX_W];
    pixel_next = '0;
    if (px_active && px_in_range) begin
      if (px_depth)      pixel_next = FB_BIT_WIDTH'(depth_pix);
      else if (px_front) pixel_next = fb1_data_in;
      else               pixel_next = fb0_data_in;
    end
  end

  // Register the final pixel once read data has returned.
  always_ff @(posedge clk_in) begin
    if (rst_in) pixel_out <= '0;
    else        pixel_out <= pixel_next;
  end

  swap_state_t state, state_next;
  logic        vsync_prev;
  logic        vsync_rise;
  logic        front_next;
  logic        ack_next;

  // Swap FSM state and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      vsync_prev   <= 1'b0;
      front_out    <= 1'b0;
      swap_ack_out <= 1'b0;
    end else begin
      state        <= state_next;
      vsync_prev   <= vsync_in;
      front_out    <= front_next;
      swap_ack_out <= ack_next;
    end
  end

  // Requests wait for a vsync edge seen while pending; extra requests are dropped.
  always_comb begin
    state_next = state;
    front_next = front_out;
    ack_next   = 1'b0;
    vsync_rise = vsync_in && !vsync_prev;
    unique case (state)
      ST_IDLE:    if (swap_req_in) state_next = ST_PENDING;
      ST_PENDING: if (vsync_rise)  state_next = ST_SWAP;
      ST_SWAP: begin
        front_next = ~front_out;
        ack_next   = 1'b1;
        state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader with a 2-cycle-latency memory model.
module tb_fb_scanout_reader;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, active_in, swap_req_in, depth_view_in;
  logic [7:0]  fb0_data_in, fb1_data_in;
  logic [15:0] dp_data_in;
  logic [16:0] rd_addr_out;
  logic        rd_en_out, front_out, swap_ack_out;
  logic [7:0]  pixel_out;
  logic        hsync_out, vsync_out, active_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fb_scanout_reader dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .active_in     (active_in),
    .swap_req_in   (swap_req_in),
    .depth_view_in (depth_view_in),
    .fb0_data_in   (fb0_data_in),
    .fb1_data_in   (fb1_data_in),
    .dp_data_in    (dp_data_in),
    .rd_addr_out   (rd_addr_out),
    .rd_en_out     (rd_en_out),
    .front_out     (front_out),
    .swap_ack_out  (swap_ack_out),
    .pixel_out     (pixel_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .active_out    (active_out)
  );

  // Memory contents are simple functions of the address; data returns 2 clocks after rd_addr_out.
  logic [16:0] mem_addr = '0;
  always @(posedge clk) begin
    mem_addr    <= rd_addr_out;
    fb0_data_in <= mem_addr[7:0] ^ 8'h18;
    fb1_data_in <= mem_addr[7:0] ^ 8'hC3;
    dp_data_in  <= 16'h1234 + 16'(mem_addr);
  end

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        act, dv, hs, vs;
    logic [16:0] addr;
    logic        en;
    logic [7:0]  pix;
  } vec_t;

  vec_t vecs [8];
  vec_t prev;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic count_ack(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      tick();
      if (swap_ack_out) n++;
    end
  endtask

  int n_ack;

  initial begin
    // h, v, act, dv, hs, vs, addr, en, pix
    vecs[0] = '{11'd8,    10'd4,   1'b1, 1'b0, 1'b0, 1'b0, 17'd322,   1'b1, 8'h5A};
    vecs[1] = '{11'd1280, 10'd4,   1'b1, 1'b0, 1'b0, 1'b0, 17'd0,     1'b0, 8'h00};
    vecs[2] = '{11'd0,    10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 17'd0,     1'b1, 8'hED};
    vecs[3] = '{11'd1279, 10'd719, 1'b1, 1'b0, 1'b0, 1'b0, 17'd57599, 1'b1, 8'hE7};
    vecs[4] = '{11'd100,  10'd720, 1'b1, 1'b0, 1'b0, 1'b0, 17'd0,     1'b0, 8'h00};
    vecs[5] = '{11'd40,   10'd8,   1'b0, 1'b0, 1'b1, 1'b0, 17'd650,   1'b0, 8'h00};
    vecs[6] = '{11'd400,  10'd200, 1'b1, 1'b1, 1'b0, 1'b1, 17'd16100, 1'b1, 8'hAE};
    vecs[7] = '{11'd12,   10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 17'd3,     1'b1, 8'h1B};
    prev    = '{11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 8'h00};

    // Reset with live inputs: outputs cleared, then 4-cycle fill.
    rst_in = 1'b1; swap_req_in = 1'b0; depth_view_in = 1'b0;
    hcount_in = 11'd8; vcount_in = 10'd4; active_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) tick();
    check("rst_addr",  32'(rd_addr_out), 32'd0);
    check("rst_en",    32'(rd_en_out),   32'd0);
    check("rst_pixel", 32'(pixel_out),   32'd0);
    check("rst_hsync", 32'(hsync_out),   32'd0);
    check("rst_vsync", 32'(vsync_out),   32'd0);
    check("rst_active",32'(active_out),  32'd0);
    check("rst_front", 32'(front_out),   32'd0);
    check("rst_ack",   32'(swap_ack_out),32'd0);
    rst_in = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("fill%0d_pixel", c),  32'(pixel_out),  32'd0);
      check($sformatf("fill%0d_hsync", c),  32'(hsync_out),  32'd0);
      check($sformatf("fill%0d_vsync", c),  32'(vsync_out),  32'd0);
      check($sformatf("fill%0d_active", c), 32'(active_out), 32'd0);
    end
    tick();
    check("fill4_pixel",  32'(pixel_out),  32'h5A);
    check("fill4_hsync",  32'(hsync_out),  32'd1);
    check("fill4_vsync",  32'(vsync_out),  32'd1);
    check("fill4_active", 32'(active_out), 32'd1);

    hcount_in = '0; vcount_in = '0; active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (4) tick();

    // Table: address after 1 cycle, previous pixel at cycle 3, new pixel at cycle 4.
    for (int i = 0; i < 8; i++) begin
      hcount_in = vecs[i].h; vcount_in = vecs[i].v; active_in = vecs[i].act;
      depth_view_in = vecs[i].dv; hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
      tick();
      check($sformatf("v%0d_addr", i), 32'(rd_addr_out), 32'(vecs[i].addr));
      check($sformatf("v%0d_en", i),   32'(rd_en_out),   32'(vecs[i].en));
      tick(); tick();
      check($sformatf("v%0d_pixel_c3", i), 32'(pixel_out), 32'(prev.pix));
      check($sformatf("v%0d_hsync_c3", i), 32'(hsync_out), 32'(prev.hs));
      tick();
      check($sformatf("v%0d_pixel", i),  32'(pixel_out),  32'(vecs[i].pix));
      check($sformatf("v%0d_hsync", i),  32'(hsync_out),  32'(vecs[i].hs));
      check($sformatf("v%0d_vsync", i),  32'(vsync_out),  32'(vecs[i].vs));
      check($sformatf("v%0d_active", i), 32'(active_out), 32'(vecs[i].act));
      prev = vecs[i];
    end

    // Swap on vsync edge; a second request while pending is dropped.
    hcount_in = 11'd8; vcount_in = 10'd4; active_in = 1'b1; depth_view_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    tick(); tick();
    swap_req_in = 1'b1; tick(); swap_req_in = 1'b0; tick();
    swap_req_in = 1'b1; tick(); swap_req_in = 1'b0; tick();
    check("front_before_edge", 32'(front_out), 32'd0);
    vsync_in = 1'b1;
    count_ack(6, n_ack);
    check("swap_ack_cycles", 32'(n_ack), 32'd1);
    check("front_after_swap", 32'(front_out), 32'd1);
    repeat (4) tick();
    check("pixel_from_fb1", 32'(pixel_out), 32'h81);
    vsync_in = 1'b0; tick(); tick(); vsync_in = 1'b1;
    count_ack(6, n_ack);
    check("no_queued_swap_ack", 32'(n_ack), 32'd0);
    check("no_queued_swap_front", 32'(front_out), 32'd1);

    // Request coincident with vsync edge: swap waits for the next edge.
    vsync_in = 1'b0; tick(); tick();
    vsync_in = 1'b1; swap_req_in = 1'b1; tick(); swap_req_in = 1'b0;
    count_ack(6, n_ack);
    check("same_edge_no_ack", 32'(n_ack), 32'd0);
    check("same_edge_front", 32'(front_out), 32'd1);
    vsync_in = 1'b0; tick(); tick(); vsync_in = 1'b1;
    count_ack(6, n_ack);
    check("next_edge_ack", 32'(n_ack), 32'd1);
    check("next_edge_front", 32'(front_out), 32'd0);

    // Reset while pending drops the request.
    vsync_in = 1'b0; tick(); tick();
    swap_req_in = 1'b1; tick(); swap_req_in = 1'b0; tick();
    rst_in = 1'b1; tick(); tick(); rst_in = 1'b0;
    check("pend_rst_front", 32'(front_out), 32'd0);
    check("pend_rst_pixel", 32'(pixel_out), 32'd0);
    tick();
    vsync_in = 1'b1;
    count_ack(6, n_ack);
    check("pend_rst_no_ack", 32'(n_ack), 32'd0);
    check("pend_rst_front_kept", 32'(front_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fb_scanout_reader.md
FB_SCANOUT_READER -- requirements
Module: fb_scanout_reader

Interface
REQ-001 SHALL have parameters: FB_ADDR_WIDTH, default 17, framebuffer/depth address width; FB_BIT_WIDTH, default 8, pixel width; DEPTH_BIT_WIDTH, default 16, depth word width; FB_W, default 320, buffer width in pixels; FB_H, default 180, buffer height in pixels; SCALE_SHIFT, default 2, screen-to-buffer downscale shift.
REQ-002 SHALL have these ports, clock and reset first:
clk_in  in  1  the single clock.
rst_in  in  1  synchronous, active-high reset.
hcount_in  in  11  screen x from video timing.
vcount_in  in  10  screen y.
hsync_in  in  1  horizontal sync.
vsync_in  in  1  vertical sync.
active_in  in  1  visible-region flag.
swap_req_in  in  1  one-cycle pulse: renderer finished the back buffer.
depth_view_in  in  1  1 = display depth buffer instead of colour.
fb0_data_in  in  FB_BIT_WIDTH  buffer 0 read data.
fb1_data_in  in  FB_BIT_WIDTH  buffer 1 read data.
dp_data_in  in  DEPTH_BIT_WIDTH  depth read data.
rd_addr_out  out  FB_ADDR_WIDTH  shared read address to fb0, fb1 and depth.
rd_en_out  out  1  read enable.
front_out  out  1  displayed buffer; the renderer writes !front_out.
swap_ack_out  out  1  one-cycle pulse when a swap takes effect.
pixel_out  out  FB_BIT_WIDTH  display pixel.
hsync_out  out  1  delayed hsync.
vsync_out  out  1  delayed vsync.
active_out  out  1  delayed active.

Function
REQ-003 SHALL use a read memory latency of exactly 2 cycles from rd_addr_out/rd_en_out to the data inputs.
REQ-004 Cycle 1 SHALL register rd_addr_out = (vcount_in>>SCALE_SHIFT)*FB_W + (hcount_in>>SCALE_SHIFT).
REQ-005 Cycle 1 SHALL register rd_en_out = active_in AND in_range, with in_range = (hcount>>S) < FB_W AND (vcount>>S) < FB_H.
REQ-006 When in_range is 0, the block SHALL hold rd_addr_out at 0.
REQ-007 Total latency SHALL be 4 cycles, inputs to pixel_out; hsync, vsync and active SHALL be delayed by the same 4 cycles.
REQ-008 The pipeline SHALL carry front_out, in_range and depth_view_in captured at cycle 1, so a pixel always uses the selection that was valid when its address was issued.
REQ-009 pixel_out SHALL be 0 when active is 0 or in_range is 0.
REQ-010 Otherwise, if depth_view is set, pixel_out SHALL be ~dp_data_in[15:8], zero-extended or truncated to FB_BIT_WIDTH.
REQ-011 Otherwise pixel_out SHALL be fb1_data_in when the captured front is 1, else fb0_data_in.
REQ-012 The swap FSM SHALL have states IDLE, PENDING and SWAP.
REQ-013 In IDLE, swap_req_in SHALL move the FSM to PENDING.
REQ-014 In PENDING, a vsync_in rising edge (vsync_in=1 while the registered previous value is 0) SHALL move the FSM to SWAP.
REQ-015 In SWAP, the block SHALL toggle front_out, pulse swap_ack_out for 1 cycle and return to IDLE.
REQ-016 swap_req_in while in PENDING or SWAP SHALL be ignored, with no queuing.
REQ-017 swap_req_in in IDLE in the same cycle as a vsync edge SHALL go to PENDING; that edge is not consumed and the swap occurs at the next frame.
REQ-018 front_out SHALL change only in the SWAP state, so a frame never mixes buffers.

Reset
REQ-019 On rst_in, all outputs SHALL be 0, the FSM SHALL be IDLE, all pipeline valid/sync stages SHALL clear, and the previous-vsync register SHALL be 0.
REQ-020 Reset mid-PENDING SHALL drop the pending swap; the renderer re-requests.
REQ-021 The first 4 cycles after reset SHALL output pixel 0 with syncs 0.

Structure
REQ-022 Video timing widths, the memory read latency (2) and the depth-to-pixel conversion width SHALL live in the shared graphics package.
REQ-023 Swap states SHALL be an enum in the same package.
REQ-024 The block SHALL have one sub-module, pipe_delay (parameterised width/depth shift register), used for the sync/flag alignment.

Verification
REQ-025 The bench SHALL drive hcount=8, vcount=4, active=1 -> rd_addr_out=322, rd_en_out=1 after 1 cycle; fb0_data=0x5A at cycle 3 -> pixel_out=0x5A at cycle 4.
REQ-026 The bench SHALL drive hcount=1280, vcount=4 (x>>2=320, out of range) -> rd_en_out=0, rd_addr_out=0, pixel_out=0 after 4 cycles.
REQ-027 The bench SHALL pulse swap_req, then drive vsync 0->1 -> swap_ack_out high for exactly 1 cycle, front_out 0->1, and subsequent pixels taken from fb1_data_in.
REQ-028 The bench SHALL assert swap_req in the same cycle as a vsync edge -> no swap that frame; the swap occurs at the next vsync edge.
REQ-029 The bench SHALL set depth_view=1 with dp_data=0x1234 -> pixel_out=0xED.
REQ-030 The bench SHALL assert rst_in while PENDING -> state IDLE, front_out unchanged from its reset value 0, no swap_ack_out at the next vsync edge.
